dcache_resp: RTL and testbench
==============================

Name: dcache_resp

Overview:
- Data-cache responder serving the ME stage's load/store requests.
- Direct-mapped, write-through, no-write-allocate.
- Publishes a 6-bit one-hot state; the ME stage only advances when the state equals `STATE_FREE`.
- Refills lines from a word-wide memory port using a request/burst-return handshake.

Parameters:
- INDEX_BITS, 4, log2 of the number of lines (16 lines).
- LINE_WORDS, 4, 32-bit words per line; power of 2, minimum 2.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  ME request present; sampled only when state == `STATE_FREE`.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address; bits [1:0] ignored.
- req_wdata  in  32  store data.
- req_wstrb  in  4  store byte enables.
- resp_valid  out  1  one-cycle pulse; load data valid, or store complete.
- resp_rdata  out  32  load data; 0 for store responses.
- state  out  6  one-hot: FREE 000001, RD_REQ 000010, RD_FILL 000100, RD_RESP 001000, WR_REQ 010000, WR_WAIT 100000.
- mem_req_valid  out  1  memory command valid.
- mem_req_ready  in  1  memory accepts the command this cycle.
- mem_we  out  1  command is a write.
- mem_addr  out  32  word address of the write, or line-aligned address of a read.
- mem_wdata  out  32  write data.
- mem_wstrb  out  4  write byte enables.
- mem_rvalid  in  1  one refill beat.
- mem_rdata  in  32  refill beat data.
- mem_bvalid  in  1  write acknowledge.

Behaviour:
- Address split: offset = addr[log2(LINE_WORDS)+1:2]; index = next INDEX_BITS bits; tag = the remaining upper bits.
- Reset:
  - state = FREE; all line valid bits cleared.
  - resp_valid = 0, resp_rdata = 0.
  - mem_req_valid = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, mem_wstrb = 0.
  - Fill counter = 0.
  - Data/tag arrays are not reset.
- FREE, request accepted; the request is captured into internal registers.
  - Load hit: next cycle resp_valid = 1 with the word; state stays FREE; back-to-back hits give 1 response per cycle.
  - Load miss: -> RD_REQ.
  - Store with wstrb != 0: on a hit, merge the enabled bytes into the line the same edge; -> WR_REQ. On a miss, do not allocate.
  - Store with wstrb == 0: no-op; no memory traffic; resp_valid pulses the next cycle; stays FREE.
- RD_REQ:
  - mem_req_valid = 1, mem_we = 0, mem_addr = line-aligned.
  - On mem_req_ready -> RD_FILL, counter = 0.
  - mem_rvalid in this state is ignored.
- RD_FILL:
  - Each mem_rvalid writes beat[counter] into the line and increments the counter.
  - On beat LINE_WORDS-1: set valid, write the tag, -> RD_RESP.
  - Gaps between beats are allowed.
- RD_RESP:
  - resp_valid = 1, resp_rdata = requested word (must equal the fill beat, not stale array contents).
  - -> FREE.
- WR_REQ:
  - mem_req_valid = 1, mem_we = 1, word address, captured wdata/wstrb.
  - On mem_req_ready -> WR_WAIT.
  - If mem_bvalid arrives in the same cycle as the accept, the store completes: resp pulse, -> FREE.
- WR_WAIT:
  - On mem_bvalid: resp_valid = 1, resp_rdata = 0, -> FREE.
- Command stability: mem_req_valid and the command fields are held stable until accepted.
- Outside FREE: req_valid is ignored (no queuing).
- Stray inputs: mem_rvalid outside RD_FILL and mem_bvalid outside WR_REQ/WR_WAIT are ignored.
- Reset mid-operation: returns to FREE next edge with all lines invalid; the partially filled line is never marked valid; outstanding memory beats after reset are ignored.
- Index wrap: addresses differing only in tag alias the same line; a refill overwrites it.

Optional Feature:
- Macro: DCACHE_STATS_EN.
- When defined:
  - Adds outputs hit_cnt[31:0] and miss_cnt[31:0], both reset to 0.
  - Load hit increments hit_cnt; load miss increments miss_cnt at FREE->RD_REQ.
  - Store hit/miss is counted the same way; wstrb == 0 stores are not counted.
  - Counters wrap at 2^32.
- When undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- After reset, load 0x0000_0040 -> RD_REQ with mem_addr = 0x40; 4 beats 0xA0..0xA3 -> RD_RESP; resp_rdata = 0xA0; then state = 000001.
- Load 0x44 immediately after that fill -> hit; resp_valid the next cycle with 0xA1; no mem_req_valid.
- Store 0x44, wdata 0xFFFF_FFFF, wstrb 0011 -> WR_REQ with mem_wstrb = 0011; with mem_req_ready held low for 3 cycles the command stays stable; bvalid -> resp; a later load of 0x44 returns 0x0000_FFFF.
- Store to uncached 0x1000 -> memory write only; a following load of 0x1000 misses (no allocate).
- Load 0x40 then load 0x440 (same index, different tag) -> second load misses and refills; a reload of 0x40 misses again.
- Assert rst after the 2nd fill beat -> state = FREE, mem_req_valid = 0; the remaining beats are ignored; a reload of the same address misses.

Source files
------------

// File: rtl/dcache_resp_if.sv
// Purpose : bundles the ME request/response bus and the word-wide memory bus of dcache_resp.
// Latency : n/a (wiring only).
// Backpressure: memory commands are held until mem_req_ready; ME requests only sampled in FREE.
// Ports   : slave modport = cache view (takes ME requests, drives memory commands);
//           master modport = environment view (ME stage plus memory model).
interface dcache_resp_if;
    // ME stage side
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [5:0]  state;

    // memory side
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        mem_bvalid;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_wstrb,
        output resp_valid, resp_rdata, state,
        output mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_req_ready, mem_rvalid, mem_rdata, mem_bvalid
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_wstrb,
        input  resp_valid, resp_rdata, state,
        input  mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_req_ready, mem_rvalid, mem_rdata, mem_bvalid
    );
endinterface

// File: rtl/dcache_resp.sv
// Purpose : direct-mapped, write-through, no-write-allocate data cache for the ME stage.
// Latency : load hit / zero-strobe store respond 1 cycle after accept; misses and stores wait on memory.
// Backpressure: ME may only issue while state == FREE; memory commands held stable until mem_req_ready.
// Ports   : clk, rst (sync, active-high); bus (dcache_resp_if.slave) carries the ME request/response
//           and memory command/refill/ack signals. Optional macro DCACHE_STATS_EN adds hit_cnt/miss_cnt.
module dcache_resp #(
    parameter int INDEX_BITS = 4,
    parameter int LINE_WORDS = 4
) (
    input  logic         clk,
    input  logic         rst,
    dcache_resp_if.slave bus
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]  hit_cnt,
    output logic [31:0]  miss_cnt
`endif
);
    localparam int OFF_BITS = $clog2(LINE_WORDS);
    localparam int TAG_BITS = 30 - OFF_BITS - INDEX_BITS;
    localparam int LINES    = 1 << INDEX_BITS;
    localparam int WORDS    = LINES * LINE_WORDS;

    localparam logic [5:0] STATE_FREE    = 6'b000001;
    localparam logic [5:0] STATE_RD_REQ  = 6'b000010;
    localparam logic [5:0] STATE_RD_FILL = 6'b000100;
    localparam logic [5:0] STATE_RD_RESP = 6'b001000;
    localparam logic [5:0] STATE_WR_REQ  = 6'b010000;
    localparam logic [5:0] STATE_WR_WAIT = 6'b100000;

    localparam logic [OFF_BITS-1:0] LAST_BEAT = OFF_BITS'(LINE_WORDS - 1);

    logic [5:0] cur, nxt;

    // storage; data and tags carry no reset, only the valid bits do
    logic [31:0]         data_mem [WORDS];
    logic [TAG_BITS-1:0] tag_mem  [LINES];
    logic [LINES-1:0]    line_vld;

    // captured request (word address)
    logic [29:0]         cap_addr;
    logic [31:0]         cap_wdata;
    logic [3:0]          cap_wstrb;
    logic [OFF_BITS-1:0] cnt;
    logic [31:0]         fill_word;
    logic                pulse;
    logic [31:0]         pulse_dat;

    logic                unused_addr_bits;
    assign unused_addr_bits = ^bus.req_addr[1:0];

    // request decode
    logic [OFF_BITS-1:0]   req_off;
    logic [INDEX_BITS-1:0] req_idx;
    logic [TAG_BITS-1:0]   req_tag;
    logic                  req_hit;
    assign req_off = bus.req_addr[OFF_BITS+1:2];
    assign req_idx = bus.req_addr[OFF_BITS+INDEX_BITS+1:OFF_BITS+2];
    assign req_tag = bus.req_addr[31 -: TAG_BITS];
    assign req_hit = line_vld[req_idx] && (tag_mem[req_idx] == req_tag);

    logic accept, ld_hit, ld_miss, st_go, st_hit, st_nop;
    assign accept  = (cur == STATE_FREE) && bus.req_valid;
    assign ld_hit  = accept && !bus.req_we && req_hit;
    assign ld_miss = accept && !bus.req_we && !req_hit;
    assign st_go   = accept && bus.req_we && (bus.req_wstrb != 4'b0000);
    assign st_hit  = st_go && req_hit;
    assign st_nop  = accept && bus.req_we && (bus.req_wstrb == 4'b0000);

    logic [OFF_BITS-1:0]   cap_off;
    logic [INDEX_BITS-1:0] cap_idx;
    logic [TAG_BITS-1:0]   cap_tag;
    assign cap_off = cap_addr[OFF_BITS-1:0];
    assign cap_idx = cap_addr[OFF_BITS+INDEX_BITS-1:OFF_BITS];
    assign cap_tag = cap_addr[29 -: TAG_BITS];

    logic beat, fill_done, wr_done;
    assign beat      = (cur == STATE_RD_FILL) && bus.mem_rvalid;
    assign fill_done = beat && (cnt == LAST_BEAT);
    // a write ack counts while the command is offered or after it was taken
    assign wr_done   = ((cur == STATE_WR_REQ) && bus.mem_req_ready && bus.mem_bvalid) ||
                       ((cur == STATE_WR_WAIT) && bus.mem_bvalid);

    // state register
    always_ff @(posedge clk) begin
        if (rst) cur <= STATE_FREE;
        else     cur <= nxt;
    end

    // next-state logic
    always_comb begin
        nxt = cur;
        unique case (cur)
            STATE_FREE: begin
                if (ld_miss)    nxt = STATE_RD_REQ;
                else if (st_go) nxt = STATE_WR_REQ;
            end
            STATE_RD_REQ:  if (bus.mem_req_ready) nxt = STATE_RD_FILL;
            STATE_RD_FILL: if (fill_done) nxt = STATE_RD_RESP;
            STATE_RD_RESP: nxt = STATE_FREE;
            STATE_WR_REQ:  if (bus.mem_req_ready) nxt = bus.mem_bvalid ? STATE_FREE : STATE_WR_WAIT;
            STATE_WR_WAIT: if (bus.mem_bvalid) nxt = STATE_FREE;
            default:       nxt = STATE_FREE;
        endcase
    end

    // outputs; command fields come from captured registers so they stay put until accepted
    always_comb begin
        bus.state         = cur;
        bus.resp_valid    = (cur == STATE_RD_RESP) || pulse;
        bus.resp_rdata    = (cur == STATE_RD_RESP) ? fill_word : pulse_dat;
        bus.mem_req_valid = (cur == STATE_RD_REQ) || (cur == STATE_WR_REQ);
        bus.mem_we        = (cur == STATE_WR_REQ);
        bus.mem_addr      = 32'h0;
        bus.mem_wdata     = 32'h0;
        bus.mem_wstrb     = 4'h0;
        if (cur == STATE_RD_REQ) begin
            bus.mem_addr = {cap_addr[29:OFF_BITS], {(OFF_BITS+2){1'b0}}};
        end else if (cur == STATE_WR_REQ) begin
            bus.mem_addr  = {cap_addr, 2'b00};
            bus.mem_wdata = cap_wdata;
            bus.mem_wstrb = cap_wstrb;
        end
    end

    // control state
    always_ff @(posedge clk) begin
        if (rst) begin
            line_vld  <= '0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            cap_wstrb <= '0;
            cnt       <= '0;
            fill_word <= '0;
            pulse     <= 1'b0;
            pulse_dat <= '0;
        end else begin
            pulse     <= ld_hit || st_nop || wr_done;
            pulse_dat <= ld_hit ? data_mem[{req_idx, req_off}] : 32'h0;
            if (accept) begin
                cap_addr  <= bus.req_addr[31:2];
                cap_wdata <= bus.req_wdata;
                cap_wstrb <= bus.req_wstrb;
            end
            if ((cur == STATE_RD_REQ) && bus.mem_req_ready) cnt <= '0;
            else if (beat)                                  cnt <= cnt + OFF_BITS'(1);
            // keep the requested beat itself so the response never reads stale array data
            if (beat && (cnt == cap_off)) fill_word <= bus.mem_rdata;
            if (fill_done) line_vld[cap_idx] <= 1'b1;
        end
    end

    // data and tag arrays
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (st_hit) begin
                for (int b = 0; b < 4; b++) begin
                    if (bus.req_wstrb[b])
                        data_mem[{req_idx, req_off}][8*b +: 8] <= bus.req_wdata[8*b +: 8];
                end
            end
            if (beat)      data_mem[{cap_idx, cnt}] <= bus.mem_rdata;
            if (fill_done) tag_mem[cap_idx]         <= cap_tag;
        end
    end

`ifdef DCACHE_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (ld_hit || st_hit)                  hit_cnt  <= hit_cnt + 32'd1;
            if (ld_miss || (st_go && !req_hit))    miss_cnt <= miss_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_dcache_resp.sv
module tb_dcache_resp;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dcache_resp_if bus();
`ifdef DCACHE_STATS_EN
    logic [31:0] hit_cnt, miss_cnt;
`endif

    dcache_resp #(.INDEX_BITS(4), .LINE_WORDS(4)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef DCACHE_STATS_EN
        ,
        .hit_cnt(hit_cnt),
        .miss_cnt(miss_cnt)
`endif
    );

    localparam logic [5:0] S_FREE    = 6'b000001;
    localparam logic [5:0] S_RD_REQ  = 6'b000010;
    localparam logic [5:0] S_RD_FILL = 6'b000100;
    localparam logic [5:0] S_RD_RESP = 6'b001000;
    localparam logic [5:0] S_WR_REQ  = 6'b010000;
    localparam logic [5:0] S_WR_WAIT = 6'b100000;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mon_exp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    // scoreboard monitor: every response pulse pops one expected word
    always @(negedge clk) begin
        if (!rst && bus.resp_valid) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL resp_unexpected: got resp 0x%08h want no response", bus.resp_rdata);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("resp_rdata", bus.resp_rdata, mon_exp);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
        chk("free_before_req", 32'(bus.state), 32'(S_FREE));
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = a;
        bus.req_wdata = wd;
        bus.req_wstrb = ws;
        cyc();
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_wdata = 32'h0;
        bus.req_wstrb = 4'h0;
    endtask

    task automatic load_miss(input logic [31:0] a, input logic [31:0] b0, input logic [31:0] b1,
                             input logic [31:0] b2, input logic [31:0] b3, input logic [31:0] exp);
        logic [31:0] bt[4];
        bt[0] = b0; bt[1] = b1; bt[2] = b2; bt[3] = b3;
        exp_q.push_back(exp);
        issue(1'b0, a, 32'h0, 4'h0);
        chk("rd_req_state", 32'(bus.state), 32'(S_RD_REQ));
        chk("rd_req_valid", 32'(bus.mem_req_valid), 32'd1);
        chk("rd_req_we", 32'(bus.mem_we), 32'd0);
        chk("rd_req_addr", bus.mem_addr, a & ~32'hF);
        // stray beat before the command is taken
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hDEAD_BEEF;
        cyc();
        bus.mem_rvalid = 1'b0;
        chk("rd_req_hold", 32'(bus.state), 32'(S_RD_REQ));
        chk("rd_req_addr_hold", bus.mem_addr, a & ~32'hF);
        bus.mem_req_ready = 1'b1;
        cyc();
        bus.mem_req_ready = 1'b0;
        chk("rd_fill_state", 32'(bus.state), 32'(S_RD_FILL));
        chk("rd_fill_noreq", 32'(bus.mem_req_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = bt[i];
            cyc();
            bus.mem_rvalid = 1'b0;
            if (i == 1) cyc();
        end
        chk("rd_resp_state", 32'(bus.state), 32'(S_RD_RESP));
        cyc();
        chk("rd_done_free", 32'(bus.state), 32'(S_FREE));
    endtask

    task automatic load_hit(input logic [31:0] a, input logic [31:0] exp);
        exp_q.push_back(exp);
        issue(1'b0, a, 32'h0, 4'h0);
        chk("hit_state", 32'(bus.state), 32'(S_FREE));
        chk("hit_noreq", 32'(bus.mem_req_valid), 32'd0);
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                         input int stall, input bit bv_same);
        exp_q.push_back(32'h0);
        issue(1'b1, a, wd, ws);
        for (int i = 0; i <= stall; i++) begin
            chk("wr_req_state", 32'(bus.state), 32'(S_WR_REQ));
            chk("wr_req_valid", 32'(bus.mem_req_valid), 32'd1);
            chk("wr_req_we", 32'(bus.mem_we), 32'd1);
            chk("wr_req_addr", bus.mem_addr, a & ~32'h3);
            chk("wr_req_wdata", bus.mem_wdata, wd);
            chk("wr_req_wstrb", 32'(bus.mem_wstrb), 32'(ws));
            if (i < stall) cyc();
        end
        bus.mem_req_ready = 1'b1;
        bus.mem_bvalid    = bv_same;
        cyc();
        bus.mem_req_ready = 1'b0;
        bus.mem_bvalid    = 1'b0;
        if (!bv_same) begin
            chk("wr_wait_state", 32'(bus.state), 32'(S_WR_WAIT));
            chk("wr_wait_noreq", 32'(bus.mem_req_valid), 32'd0);
            cyc();
            bus.mem_bvalid = 1'b1;
            cyc();
            bus.mem_bvalid = 1'b0;
        end
        chk("wr_done_free", 32'(bus.state), 32'(S_FREE));
    endtask

    initial begin
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = 32'h0;
        bus.req_wdata = 32'h0; bus.req_wstrb = 4'h0;
        bus.mem_req_ready = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'h0; bus.mem_bvalid = 1'b0;
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        chk("rst_state", 32'(bus.state), 32'(S_FREE));
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_resp_rdata", bus.resp_rdata, 32'h0);
        chk("rst_mem_req_valid", 32'(bus.mem_req_valid), 32'd0);
        chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'h0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
        chk("rst_mem_wstrb", 32'(bus.mem_wstrb), 32'd0);

        // first refill, then hits on the same line
        load_miss(32'h40, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA0);
        load_hit(32'h44, 32'hA1);

        // back-to-back hits: one response per cycle
        exp_q.push_back(32'hA2);
        exp_q.push_back(32'hA3);
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h48;
        cyc();
        bus.req_addr  = 32'h4C;
        cyc();
        bus.req_valid = 1'b0;
        chk("b2b_state", 32'(bus.state), 32'(S_FREE));
        chk("b2b_noreq", 32'(bus.mem_req_valid), 32'd0);

        // store hit with stalled accept, then merged readback
        store(32'h44, 32'hFFFF_FFFF, 4'b0011, 3, 1'b0);
        load_hit(32'h44, 32'h0000_FFFF);

        // store miss with ack alongside accept; no allocation
        store(32'h1000, 32'h1234_5678, 4'b1111, 0, 1'b1);
        load_miss(32'h1000, 32'h1234_5678, 32'hC1, 32'hC2, 32'hC3, 32'h1234_5678);

        // zero-strobe store is a no-op with a response
        exp_q.push_back(32'h0);
        issue(1'b1, 32'h48, 32'hFFFF_FFFF, 4'b0000);
        chk("nop_state", 32'(bus.state), 32'(S_FREE));
        chk("nop_noreq", 32'(bus.mem_req_valid), 32'd0);
        load_hit(32'h48, 32'hA2);

        // aliasing: same index, different tag
        load_miss(32'h440, 32'hB0, 32'hB1, 32'hB2, 32'hB3, 32'hB0);
        load_miss(32'h40, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA0);
        // requested word is the last beat
        load_miss(32'h200C, 32'hD0, 32'hD1, 32'hD2, 32'hD3, 32'hD3);

`ifdef DCACHE_STATS_EN
        chk("hit_cnt_mid", hit_cnt, 32'd6);
        chk("miss_cnt_mid", miss_cnt, 32'd6);
`endif

        // reset in the middle of a refill
        issue(1'b0, 32'h80, 32'h0, 4'h0);
        chk("abort_rd_req", 32'(bus.state), 32'(S_RD_REQ));
        bus.mem_req_ready = 1'b1;
        cyc();
        bus.mem_req_ready = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h90;
        cyc();
        bus.mem_rdata  = 32'h91;
        cyc();
        bus.mem_rvalid = 1'b0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("abort_state", 32'(bus.state), 32'(S_FREE));
        chk("abort_noreq", 32'(bus.mem_req_valid), 32'd0);
        chk("abort_noresp", 32'(bus.resp_valid), 32'd0);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h92;
        cyc();
        bus.mem_rdata  = 32'h93;
        cyc();
        bus.mem_rvalid = 1'b0;
        chk("abort_stray_free", 32'(bus.state), 32'(S_FREE));
        load_miss(32'h80, 32'hF0, 32'hF1, 32'hF2, 32'hF3, 32'hF0);
        // reset invalidated every line, including the one holding 0x40..0x4C
        load_miss(32'h44, 32'h50, 32'h51, 32'h52, 32'h53, 32'h51);

`ifdef DCACHE_STATS_EN
        chk("hit_cnt_end", hit_cnt, 32'd0);
        chk("miss_cnt_end", miss_cnt, 32'd2);
`endif

        cyc();
        cyc();
        cyc();
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
